// File: rtl/rv32i_pkg.sv
// Shared types and constants for the RV32I program loader: FSM states,
// error codes and the byte order used to pack frame data into words.
package rv32i_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN0,
      ST_LEN1,
      ST_DATA,
      ST_CHK,
      ST_DONE,
      ST_ERR
   } ld_state_t;

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_BAD_LEN  = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
   localparam logic [1:0] ERR_CHECKSUM = 2'b11;

   localparam bit FRAME_LITTLE_ENDIAN = 1'b1;

   // States in which the loader is consuming the byte stream.
   function automatic logic is_loading(ld_state_t s);
      return (s == ST_LEN0) || (s == ST_LEN1) || (s == ST_DATA) || (s == ST_CHK);
   endfunction

endpackage

// File: rtl/byte_packer.sv
// Assembles four consecutive bytes into a 32-bit word; word/word_done are
// valid combinationally in the cycle the fourth byte is presented.
module byte_packer
   import rv32i_pkg::*;
(
   input  logic        clk,
   input  logic        Reset,
   input  logic        clear,
   input  logic        en,
   input  logic [7:0]  data,
   output logic [1:0]  byte_idx,
   output logic [31:0] word,
   output logic        word_done
);

   logic [23:0] lower;

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         lower    <= '0;
         byte_idx <= '0;
      end else if (clear) begin
         lower    <= '0;
         byte_idx <= '0;
      end else if (en) begin
         case (byte_idx)
            2'd0:    lower[7:0]   <= data;
            2'd1:    lower[15:8]  <= data;
            2'd2:    lower[23:16] <= data;
            default: ;
         endcase
         byte_idx <= byte_idx + 2'd1;
      end
   end

   assign word = FRAME_LITTLE_ENDIAN ? {data, lower}
                                     : {lower[7:0], lower[15:8], lower[23:16], data};
   assign word_done = en && (byte_idx == 2'd3);

endmodule

// File: rtl/prog_loader.sv
// Streams a length-prefixed, XOR-checksummed program image into instruction
// memory and holds the core in reset until a load completes cleanly.
module prog_loader
   import rv32i_pkg::*;
#(
   parameter int IMEM_WORDS = 1024,
   parameter int TIMEOUT    = 100000
) (
   input  logic        clk,
   input  logic        Reset,
   input  logic        start,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_ready,
   output logic        imem_we,
   output logic [9:0]  imem_addr,
   output logic [31:0] imem_wd,
   output logic        core_rst,
   output logic        done,
   output logic [1:0]  err_code
);

   ld_state_t   state, state_d;
   logic [1:0]  err_d;
   logic [7:0]  len_lo;
   logic [15:0] n_words;
   logic [9:0]  word_idx;
   logic [7:0]  csum;
   logic [31:0] tcnt;

   logic        accept, pk_en, pk_done, last_word, to_hit;
   logic [1:0]  pk_idx;
   logic [31:0] pk_word;
   logic [16:0] len_rx;

   assign accept    = rx_valid && rx_ready;
   assign pk_en     = accept && !start && (state == ST_DATA);
   assign len_rx    = {1'b0, rx_data, len_lo};
   assign to_hit    = (tcnt == 32'(TIMEOUT - 1));
   assign last_word = (pk_idx == 2'd3) && ({6'b0, word_idx} == n_words - 16'd1);

   byte_packer u_packer (
      .clk       (clk),
      .Reset     (Reset),
      .clear     (start),
      .en        (pk_en),
      .data      (rx_data),
      .byte_idx  (pk_idx),
      .word      (pk_word),
      .word_done (pk_done)
   );

   always_comb begin
      state_d = state;
      err_d   = err_code;
      if (start) begin
         state_d = ST_LEN0;
         err_d   = ERR_NONE;
      end else if (accept) begin
         case (state)
            ST_LEN0: state_d = ST_LEN1;
            ST_LEN1: begin
               if (len_rx >= 17'd1 && len_rx <= 17'(IMEM_WORDS)) begin
                  state_d = ST_DATA;
               end else begin
                  state_d = ST_ERR;
                  err_d   = ERR_BAD_LEN;
               end
            end
            ST_DATA: if (last_word) state_d = ST_CHK;
            ST_CHK: begin
               if (rx_data == csum) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_ERR;
                  err_d   = ERR_CHECKSUM;
               end
            end
            default: ;
         endcase
      end else if (is_loading(state) && to_hit) begin
         state_d = ST_ERR;
         err_d   = ERR_TIMEOUT;
      end
   end

   // Outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         state     <= ST_IDLE;
         err_code  <= ERR_NONE;
         rx_ready  <= 1'b0;
         done      <= 1'b0;
         core_rst  <= 1'b1;
         imem_we   <= 1'b0;
         imem_addr <= '0;
         imem_wd   <= '0;
         len_lo    <= '0;
         n_words   <= '0;
         word_idx  <= '0;
         csum      <= '0;
         tcnt      <= '0;
      end else begin
         state    <= state_d;
         err_code <= err_d;
         rx_ready <= is_loading(state_d);
         done     <= (state_d == ST_DONE);
         core_rst <= (state_d != ST_DONE);
         imem_we  <= 1'b0;
         if (start) begin
            word_idx  <= '0;
            csum      <= '0;
            tcnt      <= '0;
            imem_addr <= '0;
         end else begin
            if (accept || !is_loading(state)) tcnt <= '0;
            else                              tcnt <= tcnt + 32'd1;
            if (accept && state == ST_LEN0) len_lo  <= rx_data;
            if (accept && state == ST_LEN1) n_words <= len_rx[15:0];
            if (pk_en) begin
               csum <= csum ^ rx_data;
               if (pk_done) begin
                  imem_we   <= 1'b1;
                  imem_wd   <= pk_word;
                  imem_addr <= word_idx;
                  if (!last_word) word_idx <= word_idx + 10'd1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized self-checking bench for prog_loader; frames and expected writes
// come from a queue-based model of the stream format.
module tb_prog_loader;

   localparam int TO = 40;

   logic        clk = 1'b0;
   logic        Reset = 1'b1;
   logic        start = 1'b0;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        rx_ready, imem_we, core_rst, done;
   logic [9:0]  imem_addr;
   logic [31:0] imem_wd;
   logic [1:0]  err_code;

   int          n_checks = 0;
   int          n_fail = 0;
   int          dbl_pulse = 0;
   logic        prev_we = 1'b0;

   logic [31:0] words_q[$];
   logic [7:0]  frame_q[$];
   logic [41:0] wq[$];

   prog_loader #(.IMEM_WORDS(1024), .TIMEOUT(TO)) dut (
      .clk       (clk),
      .Reset     (Reset),
      .start     (start),
      .rx_valid  (rx_valid),
      .rx_data   (rx_data),
      .rx_ready  (rx_ready),
      .imem_we   (imem_we),
      .imem_addr (imem_addr),
      .imem_wd   (imem_wd),
      .core_rst  (core_rst),
      .done      (done),
      .err_code  (err_code)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (imem_we === 1'b1) wq.push_back({imem_addr, imem_wd});
      if (imem_we === 1'b1 && prev_we === 1'b1) dbl_pulse <= dbl_pulse + 1;
      prev_we <= imem_we;
   end

   task automatic frame_from_words(input bit bad_chk);
      int n;
      logic [7:0] chk;
      logic [7:0] b;
      n = words_q.size();
      chk = 8'h00;
      frame_q.delete();
      frame_q.push_back(n[7:0]);
      frame_q.push_back(n[15:8]);
      for (int i = 0; i < n; i++) begin
         for (int k = 0; k < 4; k++) begin
            b = words_q[i][8*k +: 8];
            chk = chk ^ b;
            frame_q.push_back(b);
         end
      end
      if (bad_chk) chk = chk + 8'd1;
      frame_q.push_back(chk);
   endtask

   task automatic build_frame(input int n, input bit bad_chk);
      words_q.delete();
      for (int i = 0; i < n; i++) words_q.push_back($urandom);
      frame_from_words(bad_chk);
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int k;
      repeat (gap) @(negedge clk);
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b;
      k = 0;
      while (rx_ready !== 1'b1 && k < 50) begin
         @(negedge clk);
         k++;
      end
      n_checks++;
      if (k >= 50) begin
         n_fail++;
         $display("FAIL handshake: rx_ready=%b after %0d cycles, required 1", rx_ready, k);
      end
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic send_frame(input bit gaps);
      for (int i = 0; i < frame_q.size(); i++)
         send_byte(frame_q[i], gaps ? int'($urandom_range(0, 2)) : 0);
   endtask

   task automatic pulse_start();
      wq.delete();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_end();
      int k;
      k = 0;
      while (!(done === 1'b1 || err_code !== 2'b00) && k < 100) begin
         @(negedge clk);
         k++;
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_checks++;
      if ({rx_ready, imem_we, imem_addr, imem_wd, core_rst, done, err_code} !== {1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 2'b00}) begin
         n_fail++;
         $display("FAIL reset_state: rdy=%b we=%b addr=%0d wd=%h crst=%b done=%b err=%b, required 0 0 0 0 1 0 00",
                  rx_ready, imem_we, imem_addr, imem_wd, core_rst, done, err_code);
      end
      Reset = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (rx_ready !== 1'b0 || core_rst !== 1'b1) begin
         n_fail++;
         $display("FAIL idle_state: rdy=%b crst=%b, required 0 1", rx_ready, core_rst);
      end
   endtask

   task automatic test_directed_load();
      pulse_start();
      words_q = {32'h00100513, 32'h00200593};
      frame_from_words(1'b0);
      send_frame(1'b0);
      wait_end();
      n_checks++;
      if (wq.size() !== 2) begin
         n_fail++;
         $display("FAIL dir_write_count: got %0d, required 2", wq.size());
      end
      for (int i = 0; i < wq.size() && i < 2; i++) begin
         n_checks++;
         if (wq[i] !== {10'(i), words_q[i]}) begin
            n_fail++;
            $display("FAIL dir_write%0d: got addr=%0d wd=%h, required addr=%0d wd=%h", i, wq[i][41:32], wq[i][31:0], i, words_q[i]);
         end
      end
      n_checks++;
      if ({done, core_rst, err_code} !== {1'b1, 1'b0, 2'b00}) begin
         n_fail++;
         $display("FAIL dir_done: done=%b crst=%b err=%b, required 1 0 00", done, core_rst, err_code);
      end
      rx_valid = 1'b1;
      repeat (5) @(negedge clk);
      rx_valid = 1'b0;
      n_checks++;
      if ({done, rx_ready, core_rst} !== {1'b1, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL done_sticky: done=%b rdy=%b crst=%b, required 1 0 0", done, rx_ready, core_rst);
      end
   endtask

   task automatic test_bad_length();
      pulse_start();
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      n_checks++;
      if ({err_code, rx_ready, done, core_rst} !== {2'b01, 1'b0, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL len_zero: err=%b rdy=%b done=%b crst=%b, required 01 0 0 1", err_code, rx_ready, done, core_rst);
      end
      repeat (4) @(negedge clk);
      n_checks++;
      if (wq.size() !== 0 || core_rst !== 1'b1) begin
         n_fail++;
         $display("FAIL len_zero_nowrite: writes=%0d crst=%b, required 0 1", wq.size(), core_rst);
      end
      pulse_start();
      send_byte(8'h01, 0);
      send_byte(8'h04, 0);
      n_checks++;
      if (err_code !== 2'b01 || rx_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL len_1025: err=%b rdy=%b, required 01 0", err_code, rx_ready);
      end
      pulse_start();
      send_byte(8'h00, 0);
      send_byte(8'h04, 0);
      n_checks++;
      if (err_code !== 2'b00 || rx_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL len_1024: err=%b rdy=%b, required 00 1", err_code, rx_ready);
      end
   endtask

   task automatic test_chk_error();
      pulse_start();
      words_q = {32'h00000013};
      frame_from_words(1'b1);
      send_frame(1'b0);
      wait_end();
      n_checks++;
      if (wq.size() !== 1 || (wq.size() == 1 && wq[0] !== {10'd0, 32'h00000013})) begin
         n_fail++;
         $display("FAIL chk_write: count=%0d first=%h, required 1 write of 0:00000013", wq.size(), wq.size() > 0 ? wq[0] : 42'd0);
      end
      n_checks++;
      if ({err_code, done, core_rst} !== {2'b11, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL chk_err: err=%b done=%b crst=%b, required 11 0 1", err_code, done, core_rst);
      end
   endtask

   task automatic test_timeout();
      pulse_start();
      build_frame(2, 1'b0);
      for (int i = 0; i < 4; i++) send_byte(frame_q[i], 0);
      repeat (TO - 1) @(posedge clk);
      #1;
      n_checks++;
      if (err_code !== 2'b00 || rx_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL timeout_early: err=%b rdy=%b, required 00 1", err_code, rx_ready);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if ({err_code, done, core_rst} !== {2'b10, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL timeout_err: err=%b done=%b crst=%b, required 10 0 1", err_code, done, core_rst);
      end
      pulse_start();
      build_frame(2, 1'b0);
      send_frame(1'b1);
      wait_end();
      n_checks++;
      if ({done, err_code} !== {1'b1, 2'b00} || wq.size() !== 2) begin
         n_fail++;
         $display("FAIL timeout_reload: done=%b err=%b writes=%0d, required 1 00 2", done, err_code, wq.size());
      end
   endtask

   task automatic test_reset_midload();
      pulse_start();
      build_frame(3, 1'b0);
      for (int i = 0; i < 7; i++) send_byte(frame_q[i], 0);
      wq.delete();
      Reset = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({rx_ready, imem_we, imem_addr, core_rst, done, err_code} !== {1'b0, 1'b0, 10'd0, 1'b1, 1'b0, 2'b00}) begin
         n_fail++;
         $display("FAIL midload_reset: rdy=%b we=%b addr=%0d crst=%b done=%b err=%b, required 0 0 0 1 0 00",
                  rx_ready, imem_we, imem_addr, core_rst, done, err_code);
      end
      Reset = 1'b0;
      repeat (5) @(negedge clk);
      n_checks++;
      if (wq.size() !== 0) begin
         n_fail++;
         $display("FAIL midload_nowrite: writes=%0d, required 0", wq.size());
      end
      pulse_start();
      build_frame(3, 1'b0);
      send_frame(1'b1);
      wait_end();
      n_checks++;
      if (wq.size() !== 3 || (wq.size() > 0 && wq[0] !== {10'd0, words_q[0]})) begin
         n_fail++;
         $display("FAIL midload_reload: writes=%0d first=%h, required 3 starting at addr 0", wq.size(), wq.size() > 0 ? wq[0] : 42'd0);
      end
      n_checks++;
      if (done !== 1'b1) begin
         n_fail++;
         $display("FAIL midload_done: done=%b, required 1", done);
      end
   endtask

   task automatic test_start_priority();
      pulse_start();
      build_frame(1, 1'b0);
      @(negedge clk);
      start    = 1'b1;
      rx_valid = 1'b1;
      rx_data  = 8'h05;
      @(posedge clk);
      #1;
      start    = 1'b0;
      rx_valid = 1'b0;
      send_frame(1'b0);
      wait_end();
      n_checks++;
      if ({done, err_code} !== {1'b1, 2'b00} || wq.size() !== 1 || (wq.size() == 1 && wq[0] !== {10'd0, words_q[0]})) begin
         n_fail++;
         $display("FAIL start_priority: done=%b err=%b writes=%0d, required 1 00 1", done, err_code, wq.size());
      end
   endtask

   task automatic test_random_loads();
      int n;
      bit bad;
      for (int t = 0; t < 6; t++) begin
         n   = $urandom_range(1, 6);
         bad = ($urandom_range(0, 3) == 0);
         pulse_start();
         build_frame(n, bad);
         send_frame(1'b1);
         wait_end();
         n_checks++;
         if (wq.size() !== n) begin
            n_fail++;
            $display("FAIL rand%0d_count: got %0d, required %0d", t, wq.size(), n);
         end
         for (int i = 0; i < wq.size() && i < n; i++) begin
            n_checks++;
            if (wq[i] !== {10'(i), words_q[i]}) begin
               n_fail++;
               $display("FAIL rand%0d_write%0d: got %h, required %h", t, i, wq[i], {10'(i), words_q[i]});
            end
         end
         n_checks++;
         if (bad && {done, core_rst, err_code} !== {1'b0, 1'b1, 2'b11}) begin
            n_fail++;
            $display("FAIL rand%0d_badchk: done=%b crst=%b err=%b, required 0 1 11", t, done, core_rst, err_code);
         end else if (!bad && {done, core_rst, err_code} !== {1'b1, 1'b0, 2'b00}) begin
            n_fail++;
            $display("FAIL rand%0d_done: done=%b crst=%b err=%b, required 1 0 00", t, done, core_rst, err_code);
         end
      end
   endtask

   task automatic test_single_pulses();
      n_checks++;
      if (dbl_pulse !== 0) begin
         n_fail++;
         $display("FAIL we_width: %0d multi-cycle strobes, required 0", dbl_pulse);
      end
   endtask

   initial begin
      test_reset();
      test_directed_load();
      test_bad_length();
      test_chk_error();
      test_timeout();
      test_reset_midload();
      test_start_priority();
      test_random_loads();
      test_single_pulses();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
